mult_arbiter: RTL and testbench

//  Shares one sequential Multiplier (start/productDone handshake) among NUM_REQ requesters.

---
 rtl/mult_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mult_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier among NUM_REQ clients.
// Optional BUSY watchdog is enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_arbiter #(
    parameter int WIDTH          = 32,
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_multiplier,
    input  logic [NUM_REQ*WIDTH-1:0] req_multiplicand,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [2*WIDTH-1:0]       resp_product,
    output logic                     resp_err,
    output logic                     mul_start,
    output logic [WIDTH-1:0]         mul_multiplier,
    output logic [WIDTH-1:0]         mul_multiplicand,
    input  logic [2*WIDTH-1:0]       mul_product,
    input  logic                     mul_done
);

    if (NUM_REQ < 2 || ID_W < $clog2(NUM_REQ) || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("mult_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

    localparam logic [ID_W:0] NREQ = (ID_W+1)'(NUM_REQ);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic [NUM_REQ-1:0] rot;
    logic [ID_W:0]      sum;
    logic [ID_W-1:0]    grant;
    logic               found;
    logic [WIDTH-1:0]   a_sel, b_sel;

    // Rotate so bit 0 is the rr_q requester; first set bit wins.
    always_comb begin
        rot   = NUM_REQ'({req_valid, req_valid} >> rr_q);
        sum   = '0;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, rr_q} + (ID_W+1)'(k);
                if (sum >= NREQ) begin
                    sum = sum - NREQ;
                end
                grant = sum[ID_W-1:0];
            end
        end
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                a_sel = req_multiplier[i*WIDTH +: WIDTH];
                b_sel = req_multiplicand[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 12) ?
                        $clog2(TIMEOUT_CYCLES + 1) : 12;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    assign cnt_d    = (state_q == BUSY) ? cnt_q + 1'b1 : '0;
    assign resp_err = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
`else
    assign resp_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        prod_d  = prod_q;
`ifdef MULT_ARB_TIMEOUT_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    a_d     = a_sel;
                    b_d     = b_sel;
                    id_d    = grant;
                    rr_d    = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = BUSY;
            BUSY: begin
                if (mul_done) begin
                    prod_d  = mul_product;
`ifdef MULT_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                    state_d = RESP;
                end
`ifdef MULT_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
`endif
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            prod_q  <= prod_d;
        end
    end

    // rst gating keeps req_ready low while reset is held.
    assign req_ready = (rst && state_q == IDLE && found) ?
                       (NUM_REQ'(1) << grant) : '0;

    assign mul_start        = (state_q == ISSUE);
    assign resp_valid       = (state_q == RESP);
    assign resp_id          = id_q;
    assign resp_product     = prod_q;
    assign mul_multiplier   = a_q;
    assign mul_multiplicand = b_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: transaction-level model, multiplier stand-in,
// directed scenarios plus randomized traffic.
module tb_mult_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] mr [4];
    logic [31:0] md [4];
    logic [127:0] mr_f, md_f;
    logic        resp_valid, resp_ready, resp_err;
    logic [1:0]  resp_id;
    logic [63:0] resp_product;
    logic        mul_start, mul_done;
    logic [31:0] mul_multiplier, mul_multiplicand;
    logic [63:0] mul_product;

    assign mr_f = {mr[3], mr[2], mr[1], mr[0]};
    assign md_f = {md[3], md[2], md[1], md[0]};

    always #5 clk = ~clk;

    mult_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_multiplier(mr_f), .req_multiplicand(md_f),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_product(resp_product), .resp_err(resp_err),
        .mul_start(mul_start),
        .mul_multiplier(mul_multiplier), .mul_multiplicand(mul_multiplicand),
        .mul_product(mul_product), .mul_done(mul_done)
    );

    int errs = 0;
    int checks = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
        end
    endfunction

    // Transaction model: 0 waiting for a client, 1 start cycle,
    // 2 multiplier running, 3 result offered.
    int          ph = 0;
    int          m_rr = 0;
    int          m_id = 0;
    logic [31:0] m_a = '0, m_b = '0;
    logic [63:0] m_prod = '0;

    function automatic int model_grant(logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_rr + k) % 4;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int g;
        if (!rst) begin
            ph = 0; m_rr = 0; m_id = 0;
            m_a = '0; m_b = '0; m_prod = '0;
        end else begin
            case (ph)
                0: begin
                    g = model_grant(req_valid);
                    if (g >= 0) begin
                        m_id = g; m_a = mr[g]; m_b = md[g];
                        m_rr = (g + 1) % 4;
                        ph = 1;
                    end
                end
                1: ph = 2;
                2: if (mul_done) begin
                    m_prod = {32'b0, m_a} * {32'b0, m_b};
                    ph = 3;
                end
                default: if (resp_ready) ph = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        int g;
        logic [3:0] exp_rdy;
        if (!rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_mul_start", mul_start, 0);
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_resp_product", resp_product, 0);
            chk("rst_mul_ops", {mul_multiplier, mul_multiplicand}, 0);
        end else begin
            g = (ph == 0) ? model_grant(req_valid) : -1;
            exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
            chk("req_ready", req_ready, exp_rdy);
            chk("mul_start", mul_start, ph == 1);
            chk("resp_valid", resp_valid, ph == 3);
            if (ph == 1 || ph == 2) begin
                chk("mul_ops", {mul_multiplier, mul_multiplicand}, {m_a, m_b});
            end
            if (ph == 3) begin
                chk("resp_id", resp_id, m_id);
                chk("resp_product", resp_product, m_prod);
                chk("resp_err", resp_err, 0);
            end
        end
    end

    // Multiplier stand-in: random latency, bogus product when not done,
    // occasional stale done pulse during the start cycle.
    bit          pend = 0, stale_go = 0, hold_done = 0;
    int          dly = 0;
    logic [63:0] mprod = '0;

    always @(negedge clk) begin
        if (rst) begin
            if (|(req_valid & req_ready)) stale_go = ($urandom_range(0, 2) == 0);
            if (mul_start) begin
                pend  = 1;
                dly   = $urandom_range(0, 4);
                mprod = {32'b0, mul_multiplier} * {32'b0, mul_multiplicand};
            end
        end
    end

    initial begin
        mul_done = 0;
        mul_product = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                pend = 0; stale_go = 0;
                mul_done = 0;
            end else if (stale_go) begin
                stale_go = 0;
                mul_done = 1;
                mul_product = {$urandom, $urandom};
            end else if (pend && !hold_done && dly == 0) begin
                pend = 0;
                mul_done = 1;
                mul_product = mprod;
            end else begin
                if (pend && !hold_done) dly--;
                mul_done = 0;
                mul_product = {$urandom, $urandom};
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(output bit ok, output int starts);
        ok = 0;
        starts = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (mul_start) starts++;
            if (resp_valid) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errs++;
            $display("FAIL wait_resp: got no resp_valid expected one within 60 cycles");
        end
    endtask

    task automatic take_resp();
        step();
        resp_ready = 1;
        step();
        resp_ready = 0;
    endtask

    task automatic do_reset();
        step();
        rst = 0; req_valid = 0; resp_ready = 0; hold_done = 0;
        step();
        step();
        rst = 1;
    endtask

    initial begin
        bit ok;
        int starts, nresp;
        int ids[$];
        logic [63:0] prods[$];
        int exp_ids[5] = '{0, 1, 2, 3, 0};
        logic [63:0] exp_prods[5] = '{64'd10, 64'd40, 64'd90, 64'd160, 64'd10};

        rst = 0; req_valid = 0; resp_ready = 0;
        for (int i = 0; i < 4; i++) begin mr[i] = '0; md[i] = '0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_resp_id", resp_id, 0);
        chk("reset_resp_err", resp_err, 0);
        step();
        rst = 1;

        // single requester 2: 7*9
        mr[2] = 7; md[2] = 9; req_valid = 4'b0100;
        @(negedge clk);
        chk("t1_req_ready", req_ready, 4'b0100);
        step();
        req_valid = 0;
        wait_resp(ok, starts);
        chk("t1_starts", starts, 1);
        chk("t1_product", resp_product, 63);
        chk("t1_id", resp_id, 2);
        chk("t1_err", resp_err, 0);
        take_resp();

        // all four valid from reset: 0,1,2,3,0
        do_reset();
        for (int i = 0; i < 4; i++) begin mr[i] = i + 1; md[i] = 10 * (i + 1); end
        req_valid = 4'hF; resp_ready = 1;
        for (int c = 0; c < 200 && ids.size() < 5; c++) begin
            @(negedge clk);
            if (resp_valid && resp_ready) begin
                ids.push_back(int'(resp_id));
                prods.push_back(resp_product);
            end
        end
        step();
        req_valid = 0; resp_ready = 0;
        chk("t2_count", ids.size(), 5);
        for (int i = 0; i < ids.size() && i < 5; i++) begin
            chk($sformatf("t2_id%0d", i), ids[i], exp_ids[i]);
            chk($sformatf("t2_prod%0d", i), prods[i], exp_prods[i]);
        end

        // backpressure: result held 10 cycles while others wait
        mr[1] = 5; md[1] = 6; req_valid = 4'b0010;
        step();
        req_valid = 4'hF;
        wait_resp(ok, starts);
        repeat (10) begin
            @(negedge clk);
            chk("t3_valid", resp_valid, 1);
            chk("t3_product", resp_product, 30);
            chk("t3_id", resp_id, 1);
            chk("t3_ready", req_ready, 0);
        end
        step();
        req_valid = 0; resp_ready = 1;
        step();
        resp_ready = 0;

        // max operands
        mr[3] = '1; md[3] = '1; req_valid = 4'b1000;
        step();
        req_valid = 0;
        wait_resp(ok, starts);
        chk("t4_product", resp_product, 64'hFFFF_FFFE_0000_0001);
        chk("t4_id", resp_id, 3);
        take_resp();

        // reset while the multiplier is running
        hold_done = 1;
        mr[0] = 3; md[0] = 4; req_valid = 4'b0001;
        step();
        req_valid = 0;
        step();
        step();
        rst = 0;
        @(negedge clk);
        chk("t5_outputs", {mul_start, resp_valid, req_ready, resp_id}, 0);
        chk("t5_product", resp_product, 0);
        chk("t5_ops", {mul_multiplier, mul_multiplicand}, 0);
        step();
        rst = 1; hold_done = 0;
        nresp = 0;
        repeat (10) begin
            @(negedge clk);
            if (resp_valid) nresp++;
        end
        chk("t5_no_resp", nresp, 0);
        step();
        mr[1] = 11; md[1] = 13; req_valid = 4'b0010;
        step();
        req_valid = 0;
        wait_resp(ok, starts);
        chk("t5_product_after", resp_product, 143);
        chk("t5_id_after", resp_id, 1);
        take_resp();

        // randomized traffic
        repeat (600) begin
            step();
            req_valid = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                mr[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
                md[i] = $urandom;
            end
            resp_ready = ($urandom_range(0, 2) != 0);
        end
        step();
        req_valid = 0; resp_ready = 1;
        repeat (20) step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
